// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the piano key front end: key count, selection states and helpers.
// The tone stage imports the same package.
package key_conditioner_pkg;

  localparam int N_KEYS = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } sel_state_t;

  // Ceiling log2, floored at 1 so a one-cycle debounce still gets a counter bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index of the highest set bit. The result is 0 for an empty mask, and callers guard that case.
  function automatic logic [SEL_W-1:0] hi_idx(input logic [N_KEYS-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between raw pins, the conditioner (master) and the tone stage (slave).
// The release strobe is called rel because release is a reserved word.
interface key_conditioner_if;
  import key_conditioner_pkg::*;

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [SEL_W-1:0]  sel;
  logic              sel_valid;

  modport master (input key_raw, output key, press, rel, sel, sel_valid);
  modport slave  (output key_raw, input key, press, rel, sel, sel_valid);
endinterface

// File: rtl/key_conditioner_debounce_ch.sv
// One key channel: a two-flop synchroniser, a stability counter, the accepted level
// and one-cycle press/release strobes.
module key_debounce_ch #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: accept a level only after it has differed from key for DB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      key   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync_p1 == key) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key   <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
        rel   <= ~sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Four debounced key channels plus selection of the key pressed most recently.
// The selection reacts to the press/release strobes one cycle after they occur.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int FREQ        = 133000000,
  parameter int DEBOUNCE_MS = 5
) (
  input  logic               clk,
  input  logic               rst,
  key_conditioner_if.master  bus
);

  localparam int DB_CYCLES = FREQ / 1000 * DEBOUNCE_MS;
  localparam int CNT_W     = clog2(DB_CYCLES);

  logic [N_KEYS-1:0] key_w;
  logic [N_KEYS-1:0] press_w;
  logic [N_KEYS-1:0] rel_w;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key_raw (bus.key_raw[g]),
      .key     (key_w[g]),
      .press   (press_w[g]),
      .rel     (rel_w[g])
    );
  end

  sel_state_t        state, state_n;
  logic [SEL_W-1:0]  sel, sel_n;
  logic [N_KEYS-1:0] held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      sel   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
    end
  end

  // A new press always wins, even when the selected key is released in the same cycle.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    held    = key_w & ~rel_w;
    if (|press_w) begin
      sel_n   = hi_idx(press_w);
      state_n = S_HELD;
    end else if (state == S_HELD && rel_w[sel]) begin
      if (|held) sel_n = hi_idx(held);
      else       state_n = S_IDLE;
    end
  end

  assign bus.key       = key_w;
  assign bus.press     = press_w;
  assign bus.rel       = rel_w;
  assign bus.sel       = sel;
  assign bus.sel_valid = (state == S_HELD);

endmodule
